// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the boot-ROM scan/arbitration front end.
package rom_arb_pkg;

  localparam int MaxReq   = 8;
  localparam int MaxWidth = 64;

  typedef enum logic [1:0] {
    StScan  = 2'd0,
    StDrain = 2'd1,
    StServe = 2'd2
  } state_e;

  // Rotate the low w bits of v left by one; bits at and above w come back as zero.
  function automatic logic [MaxWidth-1:0] rotl1(input logic [MaxWidth-1:0] v,
                                                input int unsigned w);
    logic [MaxWidth-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < MaxWidth; b++) begin
      if (b == 0) begin
        r[b] = v[w-1];
      end else if (b < w) begin
        r[b] = v[b-1];
      end else begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, wrapping.
module rom_rr_arb
  import rom_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  output logic [NumReq-1:0] gnt_onehot_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              valid_o
);

  int idx;

  // Walk the requesters starting at the pointer and latch the first hit.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    valid_o      = 1'b0;
    idx          = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(rr_ptr_i) + k >= NumReq) ? int'(rr_ptr_i) + k - NumReq
                                           : int'(rr_ptr_i) + k;
      if (!valid_o && req_i[idx]) begin
        valid_o           = 1'b1;
        gnt_idx_o         = IdxW'(idx);
        gnt_onehot_o[idx] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/rom_arb_ctrl.sv
// Boot ROM front end: post-reset scan with rotate-xor checksum, then round-robin
// single-cycle read arbitration between NumReq requesters.
module rom_arb_ctrl
  import rom_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int Width  = 32,
  parameter int Depth  = 2048,
  parameter int Aw     = $clog2(Depth),
  parameter int ScanEn = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*Aw-1:0] addr_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [Width-1:0]     rdata_o,
  output logic                 rom_cs_o,
  output logic [Aw-1:0]        rom_addr_o,
  input  logic [Width-1:0]     rom_rdata_i,
  input  logic                 rom_dvalid_i,
  output logic                 scan_done_o,
  output logic [Width-1:0]     checksum_o
);

  localparam int     IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam state_e ResetSt = (ScanEn != 0) ? StScan : StServe;

  state_e            state_q, state_d;
  logic              live_q;
  logic [Aw-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   id_q, id_d;
  logic [Aw-1:0]     addr_hold_q, addr_hold_d;
  logic [Width-1:0]  checksum_q, checksum_d;
  logic              scan_done_q, scan_done_d;
  logic              scan_pend_q, scan_pend_d;
  logic              gnt_pend_q, gnt_pend_d;

  logic [NumReq-1:0] arb_gnt_s;
  logic [IdxW-1:0]   arb_idx_s;
  logic              arb_valid_s;
  logic [Aw-1:0]     req_addr_s;
  logic              fold_s;
  logic [Width-1:0]  csum_next_s;
  logic              cs_s;
  logic [Aw-1:0]     addr_s;
  logic [NumReq-1:0] gnt_s;
  logic [NumReq-1:0] rvalid_s;

  rom_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i        (req_i),
    .rr_ptr_i     (rr_q),
    .gnt_onehot_o (arb_gnt_s),
    .gnt_idx_o    (arb_idx_s),
    .valid_o      (arb_valid_s)
  );

  assign req_addr_s  = addr_i[int'(arb_idx_s)*Aw +: Aw];
  // Only a dvalid that answers a scan issue folds in; stray dvalids after reset are dropped.
  assign fold_s      = rom_dvalid_i & scan_pend_q;
  assign csum_next_s = Width'(rotl1(MaxWidth'(checksum_q), Width)) ^ rom_rdata_i;

  // Next-state, ROM command and grant decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    id_d        = id_q;
    addr_hold_d = addr_hold_q;
    checksum_d  = checksum_q;
    scan_done_d = scan_done_q;
    scan_pend_d = 1'b0;
    gnt_pend_d  = 1'b0;
    cs_s        = 1'b0;
    addr_s      = addr_hold_q;
    gnt_s       = '0;
    case (state_q)
      StScan: begin
        if (live_q) begin
          cs_s        = 1'b1;
          addr_s      = cnt_q;
          addr_hold_d = cnt_q;
          scan_pend_d = 1'b1;
          if (cnt_q == Aw'(Depth - 1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + Aw'(1);
          end
        end else begin
          cnt_d = '0;
        end
        if (fold_s) begin
          checksum_d = csum_next_s;
        end else begin
          checksum_d = checksum_q;
        end
      end
      StDrain: begin
        if (fold_s) begin
          checksum_d  = csum_next_s;
          scan_done_d = 1'b1;
          state_d     = StServe;
        end else begin
          state_d = StDrain;
        end
      end
      StServe: begin
        // With ScanEn=0 this raises scan_done on the first edge after reset.
        scan_done_d = 1'b1;
        if (scan_done_q && arb_valid_s) begin
          gnt_s       = arb_gnt_s;
          cs_s        = 1'b1;
          addr_s      = req_addr_s;
          addr_hold_d = req_addr_s;
          id_d        = arb_idx_s;
          gnt_pend_d  = 1'b1;
          rr_d        = (arb_idx_s == IdxW'(NumReq - 1)) ? '0 : arb_idx_s + IdxW'(1);
        end else begin
          gnt_s = '0;
        end
      end
      default: begin
        state_d = ResetSt;
      end
    endcase
  end

  // Response steering to the requester granted in the previous cycle.
  always_comb begin
    rvalid_s = '0;
    for (int i = 0; i < NumReq; i++) begin
      rvalid_s[i] = rom_dvalid_i & gnt_pend_q & (id_q == IdxW'(i));
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetSt;
      live_q      <= 1'b0;
      cnt_q       <= '0;
      rr_q        <= '0;
      id_q        <= '0;
      addr_hold_q <= '0;
      checksum_q  <= '0;
      scan_done_q <= 1'b0;
      scan_pend_q <= 1'b0;
      gnt_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      addr_hold_q <= addr_hold_d;
      checksum_q  <= checksum_d;
      scan_done_q <= scan_done_d;
      scan_pend_q <= scan_pend_d;
      gnt_pend_q  <= gnt_pend_d;
    end
  end

  assign gnt_o       = gnt_s;
  assign rvalid_o    = rvalid_s;
  assign rdata_o     = live_q ? rom_rdata_i : '0;
  assign rom_cs_o    = cs_s;
  assign rom_addr_o  = addr_s;
  assign scan_done_o = scan_done_q;
  assign checksum_o  = checksum_q;

endmodule
